// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle and single-cycle control units.
package multicycle_control_pkg;

   localparam int unsigned OPCODE_W = 6;
   localparam int unsigned ALUOP_W  = 3;
   localparam int unsigned SRCB_W   = 2;
   localparam int unsigned PCSRC_W  = 2;
   localparam int unsigned STATE_W  = 4;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
   localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;

   localparam logic [SRCB_W-1:0] SRCB_B       = 2'b00;
   localparam logic [SRCB_W-1:0] SRCB_FOUR    = 2'b01;
   localparam logic [SRCB_W-1:0] SRCB_IMM     = 2'b10;
   localparam logic [SRCB_W-1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_ILLEGAL = 4'd12
   } state_e;

   // Full control word produced per state.
   typedef struct packed {
      logic                 iord;
      logic                 mem_read;
      logic                 mem_write;
      logic                 ir_write;
      logic                 reg_dst;
      logic                 memto_reg;
      logic                 reg_write;
      logic                 alu_src_a;
      logic [SRCB_W-1:0]    alu_src_b;
      logic [ALUOP_W-1:0]   alu_op;
      logic [PCSRC_W-1:0]   pc_src;
      logic                 pc_write;
      logic                 branch;
      logic                 illegal;
   } ctrl_t;

   // Loads and stores share the address-calculation state.
   function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: control word from current state (and memory ready).
module mc_output_decode
   import multicycle_control_pkg::*;
(
   input  logic   rst_n,
   input  state_e state_i,
   input  logic   mem_ok_i,
   output ctrl_t  ctrl_o
);

   // Per-state control values; strobes cleared while reset is asserted.
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.alu_op    = ALUOP_ADD;
            ctrl_o.ir_write  = mem_ok_i;
            ctrl_o.pc_write  = mem_ok_i;
         end
         S_DECODE: begin
            ctrl_o.alu_src_b = SRCB_IMM_SH2;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl_o.iord     = 1'b1;
            ctrl_o.mem_read = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.memto_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.iord      = 1'b1;
            ctrl_o.mem_write = 1'b1;
         end
         S_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_B;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_op    = ALUOP_SUB;
            ctrl_o.pc_src    = PCSRC_ALUOUT;
            ctrl_o.branch    = 1'b1;
         end
         S_ADDIEX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_ADDIWB: begin
            ctrl_o.reg_write = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pc_src   = PCSRC_JUMP;
            ctrl_o.pc_write = 1'b1;
         end
         S_ILLEGAL: begin
            ctrl_o.illegal = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
      if (!rst_n) begin
         ctrl_o.mem_read  = 1'b0;
         ctrl_o.mem_write = 1'b0;
         ctrl_o.ir_write  = 1'b0;
         ctrl_o.reg_write = 1'b0;
         ctrl_o.pc_write  = 1'b0;
         ctrl_o.branch    = 1'b0;
         ctrl_o.illegal   = 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with Moore-decoded control outputs.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 1
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                RegDst,
   output logic                MemtoReg,
   output logic                RegWrite,
   output logic                ALUSrcA,
   output logic [SRCB_W-1:0]   ALUSrcB,
   output logic [ALUOP_W-1:0]  ALUOp,
   output logic [PCSRC_W-1:0]  PCSrc,
   output logic                PCWrite,
   output logic                Branch,
   output logic [STATE_W-1:0]  state,
   output logic                illegal
);

   state_e state_q, state_d;
   logic   mem_ok_c;
   ctrl_t  ctrl;

   // Memory handshake is bypassed when the memory never stalls.
   assign mem_ok_c = (MEM_WAIT != 0) ? mem_ready : 1'b1;

   // Next-state selection; opcode is only looked at in DECODE and MEMADR.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ok_c ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (is_mem_op(opcode))      state_d = S_MEMADR;
            else if (opcode == OP_RTYPE) state_d = S_EXEC;
            else if (opcode == OP_BEQ)   state_d = S_BRANCH;
            else if (opcode == OP_ADDI)  state_d = S_ADDIEX;
            else if (opcode == OP_J)     state_d = S_JUMP;
            else                         state_d = S_ILLEGAL;
         end
         S_MEMADR: begin
            if (opcode == OP_LW)      state_d = S_MEMRD;
            else if (opcode == OP_SW) state_d = S_MEMWR;
            else                      state_d = S_ILLEGAL;
         end
         S_MEMRD:   state_d = mem_ok_c ? S_MEMWB : S_MEMRD;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   state_d = mem_ok_c ? S_FETCH : S_MEMWR;
         S_EXEC:    state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         S_ILLEGAL: state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
   end

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   mc_output_decode u_decode (
      .rst_n    (rst_n),
      .state_i  (state_q),
      .mem_ok_i (mem_ok_c),
      .ctrl_o   (ctrl)
   );

   assign IorD     = ctrl.iord;
   assign MemRead  = ctrl.mem_read;
   assign MemWrite = ctrl.mem_write;
   assign IRWrite  = ctrl.ir_write;
   assign RegDst   = ctrl.reg_dst;
   assign MemtoReg = ctrl.memto_reg;
   assign RegWrite = ctrl.reg_write;
   assign ALUSrcA  = ctrl.alu_src_a;
   assign ALUSrcB  = ctrl.alu_src_b;
   assign ALUOp    = ctrl.alu_op;
   assign PCSrc    = ctrl.pc_src;
   assign PCWrite  = ctrl.pc_write;
   assign Branch   = ctrl.branch;
   assign illegal  = ctrl.illegal;
   assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
   logic       ALUSrcA, PCWrite, Branch, illegal;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUOp;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   multicycle_control #(.MEM_WAIT(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .IorD      (IorD),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .RegDst    (RegDst),
      .MemtoReg  (MemtoReg),
      .RegWrite  (RegWrite),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .PCSrc     (PCSrc),
      .PCWrite   (PCWrite),
      .Branch    (Branch),
      .state     (state),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      opcode    = 6'b000000;
      mem_ready = 1'b1;
      #1;
      // Reset: FETCH values with strobes suppressed
      chk("rst_state",   8'(state),   8'd0);
      chk("rst_memread", 8'(MemRead), 8'd0);
      chk("rst_irwrite", 8'(IRWrite), 8'd0);
      chk("rst_pcwrite", 8'(PCWrite), 8'd0);
      chk("rst_srcb",    8'(ALUSrcB), 8'd1);
      tick(); tick();
      rst_n  = 1'b1;
      opcode = 6'b100011;
      #1;
      chk("fetch_memread", 8'(MemRead), 8'd1);
      chk("fetch_irwrite", 8'(IRWrite), 8'd1);
      chk("fetch_pcwrite", 8'(PCWrite), 8'd1);

      // LW: 0,1,2,3,4,0
      tick(); chk("lw_s1", 8'(state), 8'd1); chk("lw_dec_srcb", 8'(ALUSrcB), 8'd3);
      chk("lw_dec_rw", 8'(RegWrite), 8'd0);
      tick(); chk("lw_s2", 8'(state), 8'd2); chk("lw_adr_srca", 8'(ALUSrcA), 8'd1);
      chk("lw_adr_srcb", 8'(ALUSrcB), 8'd2);
      tick(); chk("lw_s3", 8'(state), 8'd3); chk("lw_rd_iord", 8'(IorD), 8'd1);
      chk("lw_rd_memread", 8'(MemRead), 8'd1); chk("lw_rd_rw", 8'(RegWrite), 8'd0);
      chk("lw_rd_m2r", 8'(MemtoReg), 8'd0);
      tick(); chk("lw_s4", 8'(state), 8'd4); chk("lw_wb_rw", 8'(RegWrite), 8'd1);
      chk("lw_wb_m2r", 8'(MemtoReg), 8'd1); chk("lw_wb_dst", 8'(RegDst), 8'd0);
      tick(); chk("lw_s0", 8'(state), 8'd0); chk("lw_f_rw", 8'(RegWrite), 8'd0);
      chk("lw_f_m2r", 8'(MemtoReg), 8'd0);

      // SW with two stall cycles in MEMWR
      opcode = 6'b101011;
      tick(); chk("sw_s1", 8'(state), 8'd1);
      tick(); chk("sw_s2", 8'(state), 8'd2);
      mem_ready = 1'b0;
      tick(); chk("sw_wr1", 8'(state), 8'd5); chk("sw_mw1", 8'(MemWrite), 8'd1);
      chk("sw_iord", 8'(IorD), 8'd1);
      tick(); chk("sw_wr2", 8'(state), 8'd5); chk("sw_mw2", 8'(MemWrite), 8'd1);
      tick(); chk("sw_wr3", 8'(state), 8'd5);
      mem_ready = 1'b1;
      #1; chk("sw_mw3", 8'(MemWrite), 8'd1);
      tick(); chk("sw_s0", 8'(state), 8'd0); chk("sw_mw_off", 8'(MemWrite), 8'd0);

      // R-type then BEQ: 0,1,6,7,0,1,8,0
      opcode = 6'b000000;
      tick(); chk("r_s1", 8'(state), 8'd1);
      tick(); chk("r_s6", 8'(state), 8'd6); chk("r_aluop", 8'(ALUOp), 8'd2);
      chk("r_srca", 8'(ALUSrcA), 8'd1); chk("r_srcb", 8'(ALUSrcB), 8'd0);
      tick(); chk("r_s7", 8'(state), 8'd7); chk("r_rw", 8'(RegWrite), 8'd1);
      chk("r_dst", 8'(RegDst), 8'd1);
      tick(); chk("r_s0", 8'(state), 8'd0);
      opcode = 6'b000100;
      tick(); chk("beq_s1", 8'(state), 8'd1);
      tick(); chk("beq_s8", 8'(state), 8'd8); chk("beq_branch", 8'(Branch), 8'd1);
      chk("beq_aluop", 8'(ALUOp), 8'd1); chk("beq_pcsrc", 8'(PCSrc), 8'd1);
      tick(); chk("beq_s0", 8'(state), 8'd0); chk("beq_branch_off", 8'(Branch), 8'd0);

      // ADDI: 0,1,9,10,0
      opcode = 6'b001000;
      tick(); chk("addi_s1", 8'(state), 8'd1);
      tick(); chk("addi_s9", 8'(state), 8'd9); chk("addi_srcb", 8'(ALUSrcB), 8'd2);
      tick(); chk("addi_s10", 8'(state), 8'd10); chk("addi_rw", 8'(RegWrite), 8'd1);
      chk("addi_dst", 8'(RegDst), 8'd0);
      tick(); chk("addi_s0", 8'(state), 8'd0);

      // J then illegal opcode
      opcode = 6'b000010;
      tick(); chk("j_s1", 8'(state), 8'd1);
      tick(); chk("j_s11", 8'(state), 8'd11); chk("j_pcwrite", 8'(PCWrite), 8'd1);
      chk("j_pcsrc", 8'(PCSrc), 8'd2);
      tick(); chk("j_s0", 8'(state), 8'd0);
      opcode = 6'b111111;
      tick(); chk("ill_s1", 8'(state), 8'd1); chk("ill_pre", 8'(illegal), 8'd0);
      tick(); chk("ill_s12", 8'(state), 8'd12); chk("ill_flag", 8'(illegal), 8'd1);
      chk("ill_rw", 8'(RegWrite), 8'd0); chk("ill_mw", 8'(MemWrite), 8'd0);
      chk("ill_pcw", 8'(PCWrite), 8'd0);
      tick(); chk("ill_s0", 8'(state), 8'd0); chk("ill_off", 8'(illegal), 8'd0);

      // FETCH stall for four cycles
      mem_ready = 1'b0;
      opcode    = 6'b000010;
      #1;
      chk("stall_irw0", 8'(IRWrite), 8'd0); chk("stall_pcw0", 8'(PCWrite), 8'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_state", 8'(state), 8'd0);
         chk("stall_irw", 8'(IRWrite), 8'd0);
         chk("stall_pcw", 8'(PCWrite), 8'd0);
         chk("stall_mr", 8'(MemRead), 8'd1);
      end
      mem_ready = 1'b1;
      #1;
      chk("stall_irw1", 8'(IRWrite), 8'd1); chk("stall_pcw1", 8'(PCWrite), 8'd1);
      tick(); chk("stall_s1", 8'(state), 8'd1);
      tick(); chk("stall_s11", 8'(state), 8'd11);
      tick(); chk("stall_s0", 8'(state), 8'd0);

      // Reset asserted during MEMWR
      opcode = 6'b101011;
      tick(); tick();
      mem_ready = 1'b0;
      tick(); chk("rw_s5", 8'(state), 8'd5); chk("rw_mw", 8'(MemWrite), 8'd1);
      rst_n = 1'b0;
      #1;
      chk("rw_mw_rst", 8'(MemWrite), 8'd0); chk("rw_state_rst", 8'(state), 8'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rw_hold_state", 8'(state), 8'd0);
         chk("rw_hold_mw", 8'(MemWrite), 8'd0);
         chk("rw_hold_mr", 8'(MemRead), 8'd0);
      end
      mem_ready = 1'b1;
      rst_n     = 1'b1;
      #1;
      chk("rw_rel_state", 8'(state), 8'd0); chk("rw_rel_mr", 8'(MemRead), 8'd1);
      tick(); chk("rw_after_s1", 8'(state), 8'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_WAIT, default 1, meaning: 1 = FETCH/MEMRD/MEMWR stall until mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-002 clk  input  1  single clock, all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instruction opcode from instruction register (valid from DECODE onward).
REQ-005 mem_ready  input  1  memory access complete this cycle.
REQ-006 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-007 MemRead, MemWrite  output  1 each  memory read / write strobe.
REQ-008 IRWrite  output  1  instruction register load.
REQ-009 RegDst, MemtoReg, RegWrite  output  1 each  register-file write control.
REQ-010 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-011 ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-012 ALUOp  output  3  000 add, 001 sub, 010 decode Funct; same encoding as the single-cycle control unit.
REQ-013 PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-014 PCWrite, Branch  output  1 each  unconditional PC load / PC load if ALU zero.
REQ-015 state  output  4  current state code, debug.
REQ-016 illegal  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-017 Moore FSM; all outputs decoded combinationally from registered state (plus mem_ready where stated); unlisted outputs 0.
REQ-018 Supported opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
REQ-019 States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, ILLEGAL 12.
REQ-020 FETCH: MemRead=1, ALUSrcB=01, ALUOp=000; IRWrite=PCWrite=mem_ready; stays in FETCH until mem_ready=1, then DECODE.
REQ-021 DECODE: ALUSrcB=11, ALUOp=000; next by opcode: LW/SW->MEMADR, R->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, other->ILLEGAL.
REQ-022 MEMADR: ALUSrcA=1, ALUSrcB=10; LW->MEMRD, SW->MEMWR.
REQ-023 MEMRD: IorD=1, MemRead=1; waits for mem_ready, then MEMWB.
REQ-024 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; ->FETCH.
REQ-025 MEMWR: IorD=1, MemWrite=1; waits for mem_ready, then FETCH; MemWrite held high throughout wait.
REQ-026 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010; ->ALUWB. ALUWB: RegWrite=1, RegDst=1; ->FETCH.
REQ-027 BRANCH: ALUSrcA=1, ALUOp=001, PCSrc=01, Branch=1; ->FETCH.
REQ-028 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=000; ->ADDIWB. ADDIWB: RegWrite=1, RegDst=0; ->FETCH.
REQ-029 JUMP: PCSrc=10, PCWrite=1; ->FETCH.
REQ-030 ILLEGAL: illegal=1, no write strobes; ->FETCH (instruction skipped, PC already advanced).
REQ-031 Latency in cycles with mem_ready=1: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, illegal 3; each mem_ready=0 cycle adds 1.
REQ-032 opcode change during a wait state has no effect except at DECODE and MEMADR, where it is sampled.
REQ-033 Unused state codes 13-15 SHALL transition to FETCH with all strobes 0.

Reset
REQ-034 rst_n=0 forces state=FETCH immediately; while rst_n=0 MemRead, MemWrite, IRWrite, RegWrite, PCWrite, Branch, illegal forced 0; other outputs take FETCH values.
REQ-035 Reset mid-instruction (e.g., in MEMWR) aborts it; first edge after rst_n rises executes FETCH.

Structure
REQ-036 Shared package holds opcode constants, ALUOp, ALUSrcB, PCSrc encodings and state codes, reused by the single-cycle control unit.
REQ-037 One sub-module natural: mc_output_decode (state, mem_ready -> control outputs), combinational.

Verification
REQ-038 Reset held 3 cycles during MEMWR -> MemWrite=0 immediately, state=0 after release.
REQ-039 LW 100011, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-040 SW 101011, mem_ready low 2 cycles in MEMWR -> state 5 held 3 cycles, MemWrite=1 all 3, then 0.
REQ-041 R then BEQ -> states 0,1,6,7,0,1,8,0; ALUOp=010 in 6, Branch=1 and ALUOp=001 in 8.
REQ-042 J 000010 then opcode 111111 -> PCWrite=1, PCSrc=10 in JUMP; illegal=1 for one cycle in state 12, no RegWrite/MemWrite.
REQ-043 FETCH with mem_ready=0 for 4 cycles, MEM_WAIT=1 -> state stays 0, IRWrite=PCWrite=0 until mem_ready=1.
